mont_seq: RTL

MONT_SEQ -- requirements
Module: mont_seq

---
 rtl/mont_pkg.sv | 29 ++
 rtl/mont_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/mont_pkg.sv
`default_nettype none
// ============================================================================
// Module : mont_pkg
// Brief  : Shared encodings for the Montgomery multiplier sequencer.
// Rev    : 1.0  initial release
// ============================================================================
package mont_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ADD_A   = 3'd1,
        ST_ADD_M   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_RESOLVE = 3'd4,
        ST_SUB     = 3'd5,
        ST_COMMIT  = 3'd6,
        ST_DONE    = 3'd7
    } state_t;

    localparam logic [1:0] OP_ZERO    = 2'd0;
    localparam logic [1:0] OP_A       = 2'd1;
    localparam logic [1:0] OP_M       = 2'd2;
    localparam logic [1:0] OP_NM      = 2'd3;

    localparam logic [3:0] PHASE_HOLD = 4'd8;
    localparam logic [2:0] PHASE_LAST = 3'd5;

endpackage : mont_pkg
`default_nettype wire

// File: rtl/mont_seq.sv
`default_nettype none
// ============================================================================
// Module : mont_seq
// Brief  : Sequencer driving a carry-save Montgomery adder: N_ITER bit-serial
//          iterations, a carry-resolve sweep and bounded final subtraction.
// Rev    : 1.0  initial release
// ============================================================================
module mont_seq
    import mont_pkg::*;
#(
    parameter int unsigned N_ITER  = 512,
    parameter int unsigned MAX_SUB = 4
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [N_ITER-1:0] in_b,
    input  logic              cZero,
    input  logic              sub_done,
    output logic [1:0]        op_sel,
    output logic              enableC,
    output logic              shift,
    output logic              subtract,
    output logic [3:0]        phase,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned IW = (N_ITER > 1) ? $clog2(N_ITER) : 1;
    localparam int unsigned SW = $clog2(MAX_SUB + 1);

    state_t            r_state,    w_state_nxt;
    logic [N_ITER-1:0] r_breg,     w_breg_nxt;
    logic [IW-1:0]     r_iter,     w_iter_nxt;
    logic [SW-1:0]     r_sub,      w_sub_nxt;
    logic [2:0]        r_pcnt,     w_pcnt_nxt;
    logic              r_err,      w_err_nxt;
    logic [1:0]        r_op_sel,   w_op_sel;
    logic              r_enable_c, w_enable_c;
    logic              r_shift,    w_shift;
    logic              r_subtract, w_subtract;
    logic [3:0]        r_phase,    w_phase;
    logic              r_busy,     w_busy;
    logic              r_done,     w_done;
    logic [SW-1:0]     w_sub_inc;

    assign w_sub_inc = r_sub + SW'(1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state    <= ST_IDLE;
            r_breg     <= '0;
            r_iter     <= '0;
            r_sub      <= '0;
            r_pcnt     <= '0;
            r_err      <= 1'b0;
            r_op_sel   <= OP_ZERO;
            r_enable_c <= 1'b0;
            r_shift    <= 1'b0;
            r_subtract <= 1'b0;
            r_phase    <= PHASE_HOLD;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_breg     <= w_breg_nxt;
            r_iter     <= w_iter_nxt;
            r_sub      <= w_sub_nxt;
            r_pcnt     <= w_pcnt_nxt;
            r_err      <= w_err_nxt;
            r_op_sel   <= w_op_sel;
            r_enable_c <= w_enable_c;
            r_shift    <= w_shift;
            r_subtract <= w_subtract;
            r_phase    <= w_phase;
            r_busy     <= w_busy;
            r_done     <= w_done;
        end
    end

    // Next-state and counter update
    always_comb begin
        w_state_nxt = r_state;
        w_breg_nxt  = r_breg;
        w_iter_nxt  = r_iter;
        w_sub_nxt   = r_sub;
        w_pcnt_nxt  = r_pcnt;
        w_err_nxt   = r_err;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_ADD_A;
                    w_breg_nxt  = in_b;
                    w_iter_nxt  = '0;
                    w_sub_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            ST_ADD_A: w_state_nxt = ST_ADD_M;
            ST_ADD_M: w_state_nxt = ST_SHIFT;
            ST_SHIFT: begin
                w_breg_nxt = r_breg >> 1;
                w_iter_nxt = r_iter + IW'(1);
                if (r_iter == IW'(N_ITER - 1)) begin
                    w_state_nxt = ST_RESOLVE;
                    w_pcnt_nxt  = '0;
                end else begin
                    w_state_nxt = ST_ADD_A;
                end
            end
            ST_RESOLVE: begin
                if (r_pcnt == PHASE_LAST) begin
                    w_state_nxt = ST_SUB;
                    w_pcnt_nxt  = '0;
                end else begin
                    w_pcnt_nxt  = r_pcnt + 3'd1;
                end
            end
            ST_SUB: begin
                if (r_pcnt == PHASE_LAST) begin
                    if (sub_done) begin
                        w_state_nxt = ST_COMMIT;
                    end else if (w_sub_inc == SW'(MAX_SUB)) begin
                        w_state_nxt = ST_DONE;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_sub_nxt   = w_sub_inc;
                        w_pcnt_nxt  = '0;
                    end
                end else begin
                    w_pcnt_nxt = r_pcnt + 3'd1;
                end
            end
            ST_COMMIT: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the upcoming state so they register in step with it
    always_comb begin
        w_op_sel   = OP_ZERO;
        w_enable_c = 1'b0;
        w_shift    = 1'b0;
        w_subtract = 1'b0;
        w_phase    = PHASE_HOLD;
        w_busy     = 1'b0;
        w_done     = 1'b0;
        case (w_state_nxt)
            ST_ADD_A: begin
                w_op_sel   = OP_A;
                w_enable_c = w_breg_nxt[0];
                w_busy     = 1'b1;
            end
            ST_ADD_M: begin
                w_op_sel   = cZero ? OP_M : OP_ZERO;
                w_enable_c = cZero;
                w_busy     = 1'b1;
            end
            ST_SHIFT: begin
                w_shift = 1'b1;
                w_busy  = 1'b1;
            end
            ST_RESOLVE: begin
                w_phase = {1'b0, w_pcnt_nxt};
                w_busy  = 1'b1;
            end
            ST_SUB: begin
                w_op_sel   = OP_NM;
                w_subtract = 1'b1;
                w_phase    = {1'b0, w_pcnt_nxt};
                w_busy     = 1'b1;
            end
            ST_COMMIT: begin
                w_op_sel   = OP_NM;
                w_subtract = 1'b1;
                w_phase    = 4'd0;
                w_busy     = 1'b1;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign op_sel   = r_op_sel;
    assign enableC  = r_enable_c;
    assign shift    = r_shift;
    assign subtract = r_subtract;
    assign phase    = r_phase;
    assign busy     = r_busy;
    assign done     = r_done;
    assign err      = r_err;

endmodule : mont_seq
`default_nettype wire
